// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI responder: decodes start/SGL/D2..D0 and returns a null bit plus an N-bit result, MSB first.
// Define MCP3008_LSB_TAIL_EN to repeat B1..B(N-1) LSB-first after B0, as the real device does.
module mcp3008_responder #(
  parameter int CHANNELS = 8,
  parameter int N        = 10
) (
  input  logic                       SCLK,
  input  logic                       reset_n,
  input  logic                       CS_n,
  input  logic                       DIN,
  input  logic [CHANNELS-1:0][N-1:0] chan_data,
  output logic                       DOUT,
  output logic                       DOUT_en,
  output logic [2:0]                 req_chan,
  output logic                       req_sgl,
  output logic                       sample_strobe,
  output logic                       frame_err
);

`ifdef MCP3008_LSB_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  localparam int            CW     = $clog2(2 * N + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(2 * N);

  typedef enum logic [2:0] {IDLE, CMD, SAMPLE, DATA, TAIL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [2:0]    req_chan_q, req_chan_d;
  logic          req_sgl_q, req_sgl_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          active_q, active_d;
  logic          dout_q, dout_d;
  logic          dout_en_q, dout_en_d;

  logic [7:0][N-1:0] chan_ext;
  logic [2:0]        pos_idx, neg_idx;
  logic [N-1:0]      pos_val, neg_val, result;
  logic [N:0]        diff;

  // Missing channels read as 0; IN+ index is D2..D0 in both modes, IN- is its pair partner.
  always_comb begin
    chan_ext                 = '0;
    chan_ext[CHANNELS-1:0]   = chan_data;
    pos_idx                  = cmd_q[2:0];
    neg_idx                  = {cmd_q[2:1], ~cmd_q[0]};
    pos_val                  = chan_ext[pos_idx];
    neg_val                  = chan_ext[neg_idx];
    diff                     = {1'b0, pos_val} - {1'b0, neg_val};
    if (cmd_q[3])     result = pos_val;
    else if (diff[N]) result = '0;
    else              result = diff[N-1:0];
  end

  // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    shreg_d    = shreg_q;
    req_chan_d = req_chan_q;
    req_sgl_d  = req_sgl_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    if (CS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = (state_q == CMD) || (state_q == SAMPLE) || (state_q == DATA);
    end else begin
      unique case (state_q)
        IDLE: if (DIN) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: begin
          cmd_d = {cmd_q[2:0], DIN};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(3)) state_d = SAMPLE;
        end
        SAMPLE: begin
          shreg_d    = result;
          strobe_d   = 1'b1;
          req_chan_d = cmd_q[2:0];
          req_sgl_d  = cmd_q[3];
          cnt_d      = '0;
          state_d    = DATA;
        end
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == N_C - 1'b1) state_d = TAIL;
        end
        TAIL: if (cnt_q != LAST_C) cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
    active_d = (state_d == DATA) || (state_d == TAIL);
  end

  // Falling edge: cnt=0 is the null bit, cnt=k drives B(N-k); B0 lands in TAIL at cnt=N.
  always_comb begin
    dout_d    = 1'b0;
    dout_en_d = active_q;
    for (int i = 0; i < N; i++) begin
      if (state_q == DATA && cnt_q == CW'(N - i)) dout_d = shreg_q[i];
      if (state_q == TAIL && cnt_q == CW'(N + i) && (i == 0 || TAIL_EN)) dout_d = shreg_q[i];
    end
  end

  // NOTE: state flops use non-blocking assignment only; the shift register is reset with the rest so DOUT is defined.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      shreg_q    <= '0;
      req_chan_q <= '0;
      req_sgl_q  <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      shreg_q    <= shreg_d;
      req_chan_q <= req_chan_d;
      req_sgl_q  <= req_sgl_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  always_ff @(negedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= 1'b0;
      dout_en_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  // Gating with the rising-edge active flag lets CS_n release the bus on the same rising edge.
  assign DOUT          = dout_q & active_q;
  assign DOUT_en       = dout_en_q & active_q;
  assign req_chan      = req_chan_q;
  assign req_sgl       = req_sgl_q;
  assign sample_strobe = strobe_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: an edge-position model checks both an 8- and a 2-channel instance every SCLK.
module tb_mcp3008_responder;
  localparam int N = 10;

`ifdef MCP3008_LSB_TAIL_EN
  localparam logic [8:0] TAIL_EXP = 9'b010010101;
`else
  localparam logic [8:0] TAIL_EXP = 9'b000000000;
`endif

  logic SCLK = 1'b0;
  logic reset_n = 1'b1;
  logic CS_n = 1'b1;
  logic DIN = 1'b0;
  logic [7:0][N-1:0] chan_data = '0;

  logic dout8, en8, sgl8, strobe8, err8;
  logic dout2, en2, sgl2, strobe2, err2;
  logic [2:0] chan8, chan2;

  int n_checks = 0;
  int n_fail = 0;
  int ch_val [8];

  mcp3008_responder #(.CHANNELS(8), .N(N)) u_dut8 (
    .SCLK(SCLK), .reset_n(reset_n), .CS_n(CS_n), .DIN(DIN), .chan_data(chan_data),
    .DOUT(dout8), .DOUT_en(en8), .req_chan(chan8), .req_sgl(sgl8),
    .sample_strobe(strobe8), .frame_err(err8)
  );

  mcp3008_responder #(.CHANNELS(2), .N(N)) u_dut2 (
    .SCLK(SCLK), .reset_n(reset_n), .CS_n(CS_n), .DIN(DIN), .chan_data(chan_data[1:0]),
    .DOUT(dout2), .DOUT_en(en2), .req_chan(chan2), .req_sgl(sgl2),
    .sample_strobe(strobe2), .frame_err(err2)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the datasheet rules.
  function automatic int ref_result(input logic [3:0] c, input int nch);
    int ip, im, a, b;
    if (c[3]) begin
      ip = int'(c[2:0]);
      return (ip < nch) ? ch_val[ip] : 0;
    end
    ip = 2 * int'(c[2:1]) + int'(c[0]);
    im = 2 * int'(c[2:1]) + 1 - int'(c[0]);
    a  = (ip < nch) ? ch_val[ip] : 0;
    b  = (im < nch) ? ch_val[im] : 0;
    return (a > b) ? a - b : 0;
  endfunction

  // pos = rising edges since start bit (0 = waiting); value driven on the falling edge after r(pos).
  function automatic logic exp_dout(input int p, input int r);
    if (p >= 7 && p <= N + 6) return 1'((r >> (N + 6 - p)) & 1);
`ifdef MCP3008_LSB_TAIL_EN
    if (p >= N + 7 && p <= 2 * N + 5) return 1'((r >> (p - N - 6)) & 1);
`endif
    return 1'b0;
  endfunction

  int         pos = 0;
  logic [3:0] mcmd = '0;
  int         mres8 = 0, mres2 = 0;
  logic       m_strobe = 1'b0, m_err = 1'b0, m_sgl = 1'b0;
  logic [2:0] m_chan = '0;

  always begin : compare
    @(negedge SCLK);
    #4;
    if (!reset_n) begin
      pos = 0; mcmd = '0; mres8 = 0; mres2 = 0; m_chan = '0; m_sgl = 1'b0;
    end
    check("dout8", dout8, exp_dout(pos, mres8));
    check("dout2", dout2, exp_dout(pos, mres2));
    check("en8_pre", en8, pos >= 6);
    check("en2_pre", en2, pos >= 6);
    @(posedge SCLK);
    m_strobe = 1'b0;
    m_err    = 1'b0;
    if (!reset_n) begin
      pos = 0; mcmd = '0; mres8 = 0; mres2 = 0; m_chan = '0; m_sgl = 1'b0;
    end else if (CS_n) begin
      m_err = (pos >= 1 && pos <= N + 5);
      pos   = 0;
    end else if (pos == 0) begin
      if (DIN) pos = 1;
    end else begin
      if (pos < 40) pos++;
      if (pos >= 2 && pos <= 5) mcmd[5 - pos] = DIN;
      if (pos == 6) begin
        mres8    = ref_result(mcmd, 8);
        mres2    = ref_result(mcmd, 2);
        m_strobe = 1'b1;
        m_chan   = mcmd[2:0];
        m_sgl    = mcmd[3];
      end
    end
    #1;
    check("strobe8", strobe8, m_strobe);
    check("strobe2", strobe2, m_strobe);
    check("err8", err8, m_err);
    check("err2", err2, m_err);
    check("req_chan8", chan8, m_chan);
    check("req_chan2", chan2, m_chan);
    check("req_sgl8", sgl8, m_sgl);
    check("req_sgl2", sgl2, m_sgl);
    check("en8_post", en8, pos >= 7);
    check("en2_post", en2, pos >= 7);
  end

  logic cap8 [64];
  logic cap2 [64];
  logic capen2 [64];
  logic capst [64];
  logic caperr [64];
  logic capenp [64];
  int   n_strobe, n_err, strobe_at;
  int   last_res8, last_res2;

  task automatic drive_edge(input logic cs, input logic d, input int e);
    @(negedge SCLK);
    #1;
    CS_n = cs;
    DIN  = d;
    #3;
    cap8[e]   = dout8;
    cap2[e]   = dout2;
    capen2[e] = en2;
    @(posedge SCLK);
    #1;
    capst[e]  = strobe8;
    caperr[e] = err8;
    capenp[e] = en8;
  endtask

  task automatic set_chan(input int i, input int v);
    chan_data[i] = v[N-1:0];
    ch_val[i]    = v;
  endtask

  // CS_n low for len edges (start bit at lead+1), then one CS_n-high edge.
  task automatic run_frame(input int lead, input logic sgl, input logic [2:0] d,
                           input int len, input bit noisy);
    int s;
    s = lead + 1;
    n_strobe = 0; n_err = 0; strobe_at = 0;
    for (int e = 1; e <= len; e++) begin
      logic b;
      b = 1'b0;
      if (e == s)                    b = 1'b1;
      else if (e == s + 1)           b = sgl;
      else if (e >= s + 2 && e <= s + 4) b = d[s + 4 - e];
      else if (e > s + 4 && noisy)   b = 1'($urandom_range(0, 1));
      drive_edge(1'b0, b, e);
      if (capst[e]) begin n_strobe++; strobe_at = e; end
      if (caperr[e]) n_err++;
    end
    drive_edge(1'b1, 1'b0, len + 1);
    if (caperr[len + 1]) n_err++;
    last_res8 = 0;
    last_res2 = 0;
    if (s + N + 6 <= len) begin
      for (int i = 0; i < N; i++) begin
        last_res8 = (last_res8 << 1) | int'(cap8[s + 7 + i]);
        last_res2 = (last_res2 << 1) | int'(cap2[s + 7 + i]);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [8:0] tail;
    for (int i = 0; i < 8; i++) ch_val[i] = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge SCLK);
    #2 reset_n = 1'b1;
    #1;
    check("rst_dout", dout8, 0);
    check("rst_en", en8, 0);
    check("rst_chan", chan8, 0);
    check("rst_sgl", sgl8, 0);
    check("rst_strobe", strobe8, 0);
    check("rst_err", err8, 0);

    // Single-ended ch3, standard 3-byte frame.
    set_chan(3, 'h2A5);
    run_frame(7, 1'b1, 3'd3, 24, 1'b0);
    check("se_byte2_low", {cap8[14], cap8[15], cap8[16]}, 3'b010);
    check("se_byte3", {cap8[17], cap8[18], cap8[19], cap8[20], cap8[21], cap8[22], cap8[23], cap8[24]}, 8'hA5);
    check("se_strobes", n_strobe, 1);
    check("se_strobe_edge", strobe_at, 13);
    check("se_req_chan", chan8, 3);
    check("se_req_sgl", sgl8, 1);
    check("se_no_err", n_err, 0);

    // Pseudo-differential pair 0.
    set_chan(0, 'h300);
    set_chan(1, 'h100);
    run_frame(7, 1'b0, 3'b000, 24, 1'b0);
    check("diff_000", last_res8, 'h200);
    check("diff_000_ch2", last_res2, 'h200);
    run_frame(7, 1'b0, 3'b001, 24, 1'b0);
    check("diff_001_clamp", last_res8, 0);

    // Channel 5 is out of range for the 2-channel instance.
    set_chan(5, 'h3C7);
    run_frame(7, 1'b1, 3'd5, 24, 1'b0);
    check("oor_res8", last_res8, 'h3C7);
    check("oor_res2", last_res2, 0);
    check("oor_en_before_f6", capen2[13], 0);
    check("oor_en_after_f6", capen2[14], 1);

    // Abort at r10 (start at edge 8, CS_n high on edge 17), then a clean frame.
    run_frame(7, 1'b1, 3'd3, 16, 1'b0);
    check("abort_err", caperr[17], 1);
    check("abort_err_count", n_err, 1);
    check("abort_en_off", capenp[17], 0);
    set_chan(1, 'h155);
    run_frame(7, 1'b1, 3'd1, 24, 1'b0);
    check("after_abort_res", last_res8, 'h155);
    check("after_abort_err", n_err, 0);

    // Back-to-back frames ch0..ch3.
    set_chan(0, 'h011); set_chan(1, 'h222); set_chan(2, 'h3FF); set_chan(3, 'h0A0);
    for (int c = 0; c < 4; c++) begin
      run_frame(7, 1'b1, 3'(c), 24, 1'b0);
      check("b2b_res", last_res8, ch_val[c]);
      check("b2b_err", n_err, 0);
    end

    // Two leading zeros and a long tail.
    set_chan(3, 'h2A5);
    run_frame(2, 1'b1, 3'd3, 30, 1'b0);
    check("lead2_res", last_res8, 'h2A5);
    check("lead2_strobe_edge", strobe_at, 8);
    for (int i = 0; i < 9; i++) tail[8 - i] = cap8[3 + 17 + i];
    check("tail_bits", tail, TAIL_EXP);

    // Reset in the middle of DATA, then a fresh frame with CS_n still low.
    for (int e = 1; e <= 12; e++) drive_edge(1'b0, (e <= 5) ? 1'b1 : 1'b0, e);
    @(negedge SCLK);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_dout", dout8, 0);
    check("midrst_en", en8, 0);
    check("midrst_chan", chan8, 0);
    check("midrst_sgl", sgl8, 0);
    @(negedge SCLK);
    #2 reset_n = 1'b1;
    set_chan(2, 'h1C3);
    run_frame(3, 1'b1, 3'd2, 24, 1'b0);
    check("midrst_next_res", last_res8, 'h1C3);

    // Randomized frames, including short (aborted) ones and noisy DIN after the command.
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < 8; c++) set_chan(c, int'($urandom_range(0, 1023)));
      run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                int'($urandom_range(4, 34)), 1'b1);
      repeat ($urandom_range(0, 1)) drive_edge(1'b1, 1'b0, 63);
    end

    drive_edge(1'b1, 1'b0, 63);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcp3008_responder.md
Name: mcp3008_responder

Overview:
- Synthesizable SPI responder that behaves like an MCP3008 ADC on the DIN/DOUT/SCLK/CS_n wires.
- Lets the SPI master run in FPGA loopback or a bench without the physical chip.
- Sample values come from parallel per-channel inputs (test registers, NCO, fixed patterns).
- Decodes the start/SGL/D2..D0 command and returns a null bit plus an N-bit result, MSB first.

Parameters:
- CHANNELS, 8, number of emulated input channels (1..8); command index >= CHANNELS returns 0.
- N, 10, result width in bits.

Ports:
- SCLK  input  1  SPI clock from master; sole clock (rising and falling edges used).
- reset_n  input  1  asynchronous, active-low reset.
- CS_n  input  1  chip select from master, active low; sampled on rising SCLK.
- DIN  input  1  command bits from master; sampled on rising SCLK.
- chan_data  input  CHANNELS x N  per-channel sample value; must be stable around the sample edge.
- DOUT  output  1  result bit to master; updated on falling SCLK.
- DOUT_en  output  1  high while DOUT is actively driven; top level tri-states DOUT when low.
- req_chan  output  3  D2..D0 of the last accepted command.
- req_sgl  output  1  SGL/DIFF bit of the last accepted command.
- sample_strobe  output  1  one-SCLK pulse on the rising edge that latches the sample.
- frame_err  output  1  one-SCLK pulse when CS_n rises before B0 has been driven.

Behaviour:
- Reset values:
  - DOUT=0, DOUT_en=0, req_chan=0, req_sgl=0, sample_strobe=0, frame_err=0.
  - State=IDLE, internal shift register=0.
- Edge numbering: r1 is the rising edge where DIN=1 is first sampled with CS_n=0 (start bit). rk and fk are the k-th rising edge and the falling edge after it.
- State machine, advanced on rising SCLK:
  - IDLE: leading DIN=0 bits are ignored; at r1 go to CMD.
  - CMD: r2=SGL, r3=D2, r4=D1, r5=D0; at r5 go to SAMPLE.
  - SAMPLE: at r6 latch result into shift register, pulse sample_strobe, update req_sgl/req_chan; go to DATA.
  - DATA: f6 drives null bit 0 and sets DOUT_en=1; f7..f16 drive B9..B0 (N-1..0 for general N); after f16 go to TAIL.
  - TAIL: see Optional Feature; stays until CS_n rises.
- CS_n high at any rising edge:
  - State becomes IDLE, DOUT_en clears at that edge, DOUT=0.
  - If state was CMD, SAMPLE or DATA (B0 not yet driven), frame_err pulses high for that SCLK period.
  - A new frame may begin at the next rising edge with CS_n low.
- Result arithmetic, SGL=1: result = chan_data[D2..D0]; 0 if index >= CHANNELS.
- Result arithmetic, SGL=0 (pseudo-differential):
  - Pair p = D2..D1 uses channels 2p and 2p+1.
  - D0=0: IN+ = ch 2p, IN- = ch 2p+1. D0=1: IN+ = ch 2p+1, IN- = ch 2p.
  - result = max(IN+ - IN-, 0), computed in N+1 bits and clamped at 0.
  - Any pair channel >= CHANNELS reads as 0.
- Latency: null bit available to the master at r7, MSB at r8, LSB at r17; 17 rising edges from start bit to LSB.
- A continuously running SCLK with CS_n held low for exactly 24 edges (3 bytes, 0x01 / {SGL,D2..D0,0000} / 0x00) must be served back-to-back without loss.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh start bit.

Optional Feature:
- Macro: MCP3008_LSB_TAIL_EN.
- Defined: after B0, f17..f25 drive B1..B(N-1) (LSB-first repeat, as the real device does); then DOUT=0 with DOUT_en held high until CS_n rises.
- Undefined: in TAIL, DOUT=0 with DOUT_en high until CS_n rises.

Test Plan:
- Single-ended ch3: chan_data[3]=0x2A5, bytes 0x01/0xB0/0x00 -> received byte2[2:0]=0b010 (null 0, B9 1, B8 0), byte3=0xA5, sample_strobe one pulse at r6, req_chan=3, req_sgl=1.
- Pseudo-differential: ch0=0x300, ch1=0x100, command SGL=0 D=000 -> result 0x200; D=001 -> result 0x000 (clamped).
- Out-of-range channel: CHANNELS=2, command ch5 single-ended -> result 0x000, DOUT_en still asserted from f6.
- Abort: CS_n raised at r10 (mid-DATA) -> frame_err one pulse, DOUT_en=0 from r10; next full frame on ch1 (0x155) returns 0x155 correctly.
- Back-to-back: 4 consecutive 24-edge frames cycling ch0..ch3 with one idle CS_n-high edge between -> each returns its channel value, no frame_err.
- Leading zeros/tail: two DIN=0 bits before the start bit -> frame decoded correctly shifted by 2 edges. With MCP3008_LSB_TAIL_EN, result 0x2A5 -> f17..f25 drive 0,1,0,0,1,0,1,0,1; without it, those edges drive 0.
